// File: rtl/wei_fifo_rd_arbiter_pkg.sv
// Shared defaults and helpers for the weight-FIFO read arbiter and its round-robin picker.
// The defaults match the weight FIFO instance so both sides agree on partition count and word width.
package wei_fifo_rd_arbiter_pkg;

    localparam int WEI_RD_NUM     = 27;
    localparam int WEI_DATA_WIDTH = 64;

    // Index width for n entries; never less than 1 bit so a single-entry build still has a port.
    function automatic int c_log_2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wei_fifo_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set bit of i_elig at or after i_start, wrapping.
// Built as a double-width mask-and-priority-encode so it can be reused by other arbiters.
module wei_fifo_rd_arbiter_rr_pick
    import wei_fifo_rd_arbiter_pkg::*;
#(
    parameter int N  = WEI_RD_NUM,
    parameter int IW = c_log_2(N)
) (
    input  logic [N-1:0]  i_elig,
    input  logic [IW-1:0] i_start,
    output logic          o_vld,
    output logic [IW-1:0] o_idx
);

    logic [2*N-1:0] w_dbl;
    logic [2*N-1:0] w_low_mask;
    int             w_pos;

    // Lower copy has the bits below start cleared, so the upper copy supplies the wrapped part.
    always_comb begin
        w_low_mask = '0;
        for (int j = 0; j < N; j++) begin
            w_low_mask[j] = (j < int'(i_start));
        end
        w_dbl = {i_elig, i_elig} & ~w_low_mask;
    end

    always_comb begin
        w_pos = 0;
        for (int j = 2*N-1; j >= 0; j--) begin
            if (w_dbl[j]) w_pos = j;
        end
    end

    assign o_vld = |i_elig;
    assign o_idx = IW'((w_pos >= N) ? (w_pos - N) : w_pos);

endmodule

// File: rtl/wei_fifo_rd_arbiter.sv
// Round-robin read scheduler: one pop per cycle into the shared weight FIFO read port,
// with the returned SRAM word tagged back to the granted requester one cycle later.
module wei_fifo_rd_arbiter
    import wei_fifo_rd_arbiter_pkg::*;
#(
    parameter int RD_NUM     = WEI_RD_NUM,
    parameter int DATA_WIDTH = WEI_DATA_WIDTH,
    parameter int ID_WIDTH   = c_log_2(RD_NUM)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [RD_NUM-1:0]     i_req,
    output logic [RD_NUM-1:0]     o_ack,
    input  logic [RD_NUM-1:0]     i_fifo_empty,
    output logic                  o_fifo_pop,
    output logic [ID_WIDTH-1:0]   o_fifo_pop_id,
    input  logic [DATA_WIDTH-1:0] i_fifo_data_out,
    output logic [RD_NUM-1:0]     o_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    output logic                  o_busy
);

    localparam logic [ID_WIDTH-1:0] LAST_IDX = ID_WIDTH'(RD_NUM - 1);

    logic [ID_WIDTH-1:0] r_last_grant;
    logic [ID_WIDTH-1:0] r_last_id;
    logic                r_last_vld;
    logic [RD_NUM-1:0]   r_ack;
    logic                r_rsp_pipe_vld;
    logic [ID_WIDTH-1:0] r_rsp_pipe_id;

    logic [RD_NUM-1:0]   w_inflight;
    logic [RD_NUM-1:0]   w_elig;
    logic [ID_WIDTH-1:0] w_start;
    logic                w_pick_vld;
    logic [ID_WIDTH-1:0] w_pick;

    // The empty flag of the id popped last cycle has not caught up yet, so mask that id.
    assign w_inflight = r_last_vld ? (RD_NUM'(1) << r_last_id) : '0;
    assign w_elig     = i_req & ~i_fifo_empty & ~w_inflight;
    assign w_start    = (r_last_grant == LAST_IDX) ? '0 : r_last_grant + ID_WIDTH'(1);

    wei_fifo_rd_arbiter_rr_pick #(
        .N  (RD_NUM),
        .IW (ID_WIDTH)
    ) u_rr_pick (
        .i_elig  (w_elig),
        .i_start (w_start),
        .o_vld   (w_pick_vld),
        .o_idx   (w_pick)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_last_grant   <= LAST_IDX;
            r_last_id      <= '0;
            r_last_vld     <= 1'b0;
            r_ack          <= '0;
            r_rsp_pipe_vld <= 1'b0;
            r_rsp_pipe_id  <= '0;
        end else begin
            r_last_vld     <= w_pick_vld;
            r_ack          <= w_pick_vld ? (RD_NUM'(1) << w_pick) : '0;
            if (w_pick_vld) begin
                r_last_grant <= w_pick;
                r_last_id    <= w_pick;
            end
            r_rsp_pipe_vld <= r_last_vld;
            r_rsp_pipe_id  <= r_last_id;
        end
    end

    assign o_ack         = r_ack;
    assign o_fifo_pop    = r_last_vld;
    assign o_fifo_pop_id = r_last_id;
    assign o_rsp_valid   = r_rsp_pipe_vld ? (RD_NUM'(1) << r_rsp_pipe_id) : '0;
    assign o_rsp_data    = i_fifo_data_out;
    assign o_busy        = r_last_vld | r_rsp_pipe_vld;

endmodule

// File: tb/tb_wei_fifo_rd_arbiter.sv
// Bench for wei_fifo_rd_arbiter: directed vector table, hand sequences, and a random
// run checked against a scan-based round-robin reference model plus a scoreboard.
module tb_wei_fifo_rd_arbiter;

    localparam int N  = 27;
    localparam int DW = 64;
    localparam int IW = 5;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  ack;
    logic [N-1:0]  empty;
    logic          pop;
    logic [IW-1:0] pop_id;
    logic [DW-1:0] din;
    logic [N-1:0]  rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          busy;

    wei_fifo_rd_arbiter #(.RD_NUM(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .i_clk(clk), .i_reset(rst), .i_req(req), .o_ack(ack),
        .i_fifo_empty(empty), .o_fifo_pop(pop), .o_fifo_pop_id(pop_id),
        .i_fifo_data_out(din), .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data),
        .o_busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state
    int m_lg, m_pop, m_id, m_rsp, m_rsp_id;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] em);
        int g;
        if (r) begin
            m_lg = N - 1; m_pop = 0; m_id = 0; m_rsp = 0; m_rsp_id = 0;
        end else begin
            m_rsp = m_pop; m_rsp_id = m_id;
            g = -1;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_lg + k) % N;
                if (rq[c] && !em[c] && !(m_pop == 1 && m_id == c)) begin
                    g = c;
                    break;
                end
            end
            if (g >= 0) begin m_pop = 1; m_id = g; m_lg = g; end
            else m_pop = 0;
        end
    endtask

    // Drive one cycle, advance the model over the same edge, sample #1 after the edge.
    task automatic cyc(input logic r, input logic [N-1:0] rq, input logic [N-1:0] em);
        rst = r; req = rq; empty = em;
        din = {$urandom, $urandom};
        model_step(r, rq, em);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_model();
        logic [N-1:0] exp_ack, exp_rsp;
        exp_ack = (m_pop == 1) ? (N'(1) << m_id) : '0;
        exp_rsp = (m_rsp == 1) ? (N'(1) << m_rsp_id) : '0;
        chk("model_pop", 64'(pop), 64'(m_pop));
        chk("model_ack", 64'(ack), 64'(exp_ack));
        if (m_pop == 1) chk("model_pop_id", 64'(pop_id), 64'(m_id));
        chk("model_rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
        chk("model_busy", 64'(busy), 64'(m_pop | m_rsp));
        chk("rsp_data", rsp_data, din);
    endtask

    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        logic [N-1:0] empty;
        logic         e_pop;
        int           e_id;
        logic [N-1:0] e_rsp;
        logic         e_busy;
    } vec_t;

    vec_t vt[12];

    initial begin
        logic [N-1:0] b3, b4, b34, all1, rq, em, prev_ack;
        int           waitc[N];
        int           prev_pop, prev_id, maxw;

        b3 = N'(1) << 3; b4 = N'(1) << 4; b34 = b3 | b4; all1 = '1;
        rst = 1'b1; req = '0; empty = '0; din = '0;

        vt[0]  = '{1'b1, '0,      '0, 1'b0, 0, '0,        1'b0};
        vt[1]  = '{1'b0, N'(1),   '0, 1'b1, 0, '0,        1'b1};
        vt[2]  = '{1'b0, '0,      '0, 1'b0, 0, N'(1),     1'b1};
        vt[3]  = '{1'b0, '0,      '0, 1'b0, 0, '0,        1'b0};
        vt[4]  = '{1'b0, b34,     b3, 1'b1, 4, '0,        1'b1};
        vt[5]  = '{1'b0, b34,     b3, 1'b0, 0, b4,        1'b1};
        vt[6]  = '{1'b0, b34,     b3, 1'b1, 4, '0,        1'b1};
        vt[7]  = '{1'b0, b34,     '0, 1'b1, 3, b4,        1'b1};
        vt[8]  = '{1'b0, b34,     '0, 1'b1, 4, b3,        1'b1};
        vt[9]  = '{1'b0, b34,     '0, 1'b1, 3, b4,        1'b1};
        vt[10] = '{1'b1, b34,     '0, 1'b0, 0, '0,        1'b0};
        vt[11] = '{1'b0, b34,     '0, 1'b1, 3, '0,        1'b1};

        cyc(1'b1, '0, '0);
        for (int i = 0; i < 12; i++) begin
            cyc(vt[i].rst, vt[i].req, vt[i].empty);
            chk($sformatf("vec%0d_pop", i), 64'(pop), 64'(vt[i].e_pop));
            chk($sformatf("vec%0d_ack", i), 64'(ack),
                vt[i].e_pop ? 64'(N'(1) << vt[i].e_id) : 64'd0);
            if (vt[i].e_pop) chk($sformatf("vec%0d_id", i), 64'(pop_id), 64'(vt[i].e_id));
            if (vt[i].rst) chk($sformatf("vec%0d_id_rst", i), 64'(pop_id), 64'd0);
            chk($sformatf("vec%0d_rsp", i), 64'(rsp_valid), 64'(vt[i].e_rsp));
            chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(vt[i].e_busy));
            chk($sformatf("vec%0d_data", i), rsp_data, din);
        end

        // all requesting, all non-empty: strict 0..26 rotation with no gaps
        cyc(1'b1, '0, '0);
        for (int i = 0; i < 60; i++) begin
            cyc(1'b0, all1, '0);
            chk("rr_all_pop", 64'(pop), 64'd1);
            chk("rr_all_id", 64'(pop_id), 64'(i % N));
            chk("rr_all_ack", 64'(ack), 64'(N'(1) << (i % N)));
            chk_model();
        end

        // single requester held high: pops only every other cycle
        cyc(1'b1, '0, '0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, N'(1) << 5, '0);
            chk("solo5_pop", 64'(pop), 64'((i % 2) == 0));
            if ((i % 2) == 0) chk("solo5_id", 64'(pop_id), 64'd5);
        end

        // random run with reference model and scoreboard
        cyc(1'b1, '0, '0);
        prev_pop = 0; prev_id = 0; prev_ack = '0;
        for (int i = 0; i < N; i++) waitc[i] = 0;
        for (int t = 0; t < 1000; t++) begin
            rq = N'({$urandom, $urandom}) | N'($urandom);
            em = N'($urandom) & N'($urandom) & N'($urandom);
            cyc(1'b0, rq, em);
            chk_model();
            chk("sb_ack_onehot0", 64'($onehot0(ack)), 64'd1);
            chk("sb_rsp_follows_ack", 64'(rsp_valid), 64'(prev_ack));
            if (pop) begin
                chk("sb_id_range", 64'(pop_id < N), 64'd1);
                if (pop_id < N) chk("sb_not_empty", 64'(em[pop_id]), 64'd0);
                if (prev_pop == 1) chk("sb_no_repeat", 64'(pop_id != IW'(prev_id)), 64'd1);
            end
            maxw = 0;
            for (int i = 0; i < N; i++) begin
                if (ack[i]) waitc[i] = 0;
                else if (rq[i] && !em[i]) waitc[i]++;
                else waitc[i] = 0;
                if (waitc[i] > maxw) maxw = waitc[i];
            end
            chk("sb_starvation", 64'(maxw <= 2*N), 64'd1);
            prev_pop = int'(pop); prev_id = int'(pop_id); prev_ack = ack;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
